and_input_debouncer: RTL

- Front-end conditioning stage directly upstream of the two-input AND gate.
- Takes two raw, asynchronous, possibly bouncing inputs (switches/buttons) and delivers clean, glitch-free input_1/input_2 levels to the gate.
- Each channel has its own two-flop synchroniser and counter-based debounce FSM.
- Also emits single-cycle edge pulses so downstream logic can count transitions.

---
 rtl/and_input_debouncer.sv | 99 +++++++++
 1 files changed

// File: rtl/and_input_debouncer.sv
// and_input_debouncer: synchronises and debounces two raw inputs for an AND gate, with edge pulses
//   clk, rst_n           : clock, asynchronous active-low reset
//   raw_1, raw_2         : raw asynchronous (bouncing) inputs
//   input_1, input_2     : debounced levels feeding the AND gate
//   rise_*, fall_*       : one-cycle pulses on each debounced edge
//   changed              : one-cycle OR of all four edge pulses
module debounce_channel #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall,
  output logic done
);
  typedef enum logic [1:0] {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  state_t state;
  logic s1, s2;
  logic [CNT_WIDTH-1:0] cnt;
  // qualification completes this cycle; lets the top register a coincident changed pulse
  assign done = ((state == CHECK_HIGH && s2) || (state == CHECK_LOW && !s2)) && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      state <= STABLE_LOW;
      out <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LOW: begin
          state <= s2 ? CHECK_HIGH : STABLE_LOW;
          cnt <= CNT_WIDTH'(s2);
        end
        CHECK_HIGH:
          if (!s2) begin
            state <= STABLE_LOW;
            cnt <= '0;
          end else if (cnt == LAST) begin
            out <= 1'b1;
            rise <= 1'b1;
            state <= STABLE_HIGH;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        STABLE_HIGH: begin
          state <= s2 ? STABLE_HIGH : CHECK_LOW;
          cnt <= CNT_WIDTH'(!s2);
        end
        CHECK_LOW:
          if (s2) begin
            state <= STABLE_HIGH;
            cnt <= '0;
          end else if (cnt == LAST) begin
            out <= 1'b0;
            fall <= 1'b1;
            state <= STABLE_LOW;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
      endcase
    end
endmodule

module and_input_debouncer #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_1,
  input  logic raw_2,
  output logic input_1,
  output logic input_2,
  output logic rise_1,
  output logic fall_1,
  output logic rise_2,
  output logic fall_2,
  output logic changed
);
  logic done_1, done_2;
  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) ch_1 (
    .clk(clk), .rst_n(rst_n), .raw(raw_1), .out(input_1), .rise(rise_1), .fall(fall_1), .done(done_1)
  );
  debounce_channel #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) ch_2 (
    .clk(clk), .rst_n(rst_n), .raw(raw_2), .out(input_2), .rise(rise_2), .fall(fall_2), .done(done_2)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) changed <= 1'b0;
    else changed <= done_1 | done_2;
endmodule
